// File: rtl/mic_capture_ctrl.sv
// Sequencing and round-robin merge controller for a bank of NUM_CH CIC decimators.
// Define MIC_CAPTURE_TSTAMP_EN to add a per-sample 32-bit timestamp output (m_tstamp).
module mic_capture_ctrl #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned SETTLE_SAMPLES = 2,
    parameter int unsigned RST_CYCLES     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_wr,
    input  logic [4:0]               cfg_comb_num,
    input  logic [7:0]               cfg_dec_num,
    input  logic                     start,
    input  logic                     stop,
    output logic                     busy,
    output logic                     cic_rst,
    output logic [4:0]               cic_comb_num,
    output logic [7:0]               cic_dec_num,
    input  logic [NUM_CH*DATA_W-1:0] cic_data,
    input  logic [NUM_CH-1:0]        cic_valid,
    output logic [DATA_W-1:0]        m_data,
    output logic [2:0]               m_chan,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [NUM_CH-1:0]        ovf,
    input  logic                     ovf_clr
`ifdef MIC_CAPTURE_TSTAMP_EN
    ,
    output logic [31:0]              m_tstamp
`endif
);

    localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned RCNT_W = 8;
    localparam int unsigned COMB_W = 5;
    localparam int unsigned DEC_W  = 8;
    localparam int unsigned CHAN_W = 3;
`ifdef MIC_CAPTURE_TSTAMP_EN
    localparam int unsigned TS_W   = 32;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_SETTLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic [CNT_W-1:0]    scnt_q [NUM_CH];
    logic [CNT_W-1:0]    scnt_d [NUM_CH];
    logic [COMB_W-1:0]   comb_q, comb_d;
    logic [DEC_W-1:0]    dec_q, dec_d;
    logic                busy_q, busy_d;
    logic                cic_rst_q, cic_rst_d;

    logic [DATA_W-1:0]   hold_data_q [NUM_CH];
    logic [DATA_W-1:0]   hold_data_d [NUM_CH];
    logic [NUM_CH-1:0]   hold_full_q, hold_full_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [CHAN_W-1:0]   m_chan_q, m_chan_d;
    logic                m_valid_q, m_valid_d;
    logic [NUM_CH-1:0]   ovf_q, ovf_d;
    logic [NUM_CH-1:0]   ovf_set;

`ifdef MIC_CAPTURE_TSTAMP_EN
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [TS_W-1:0]     hold_ts_q [NUM_CH];
    logic [TS_W-1:0]     hold_ts_d [NUM_CH];
    logic [TS_W-1:0]     m_tstamp_q, m_tstamp_d;
`endif

    logic                start_take;
    logic                settle_done;
    logic                arb_found;
    logic [IDX_W-1:0]    arb_sel;
    logic                grant;

    assign start_take = (state_q == S_IDLE) && start;
    assign grant      = arb_found && (!m_valid_q || m_ready);

    // Round-robin search over full registers, starting after the last grant.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = last_grant_q;
        for (int i = 1; i <= int'(NUM_CH); i++) begin
            if (!arb_found &&
                hold_full_q[IDX_W'((int'(last_grant_q) + i) % int'(NUM_CH))]) begin
                arb_found = 1'b1;
                arb_sel   = IDX_W'((int'(last_grant_q) + i) % int'(NUM_CH));
            end
        end
    end

    always_comb begin
        settle_done = 1'b1;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (scnt_q[k] < CNT_W'(SETTLE_SAMPLES)) begin
                settle_done = 1'b0;
            end
        end
    end

    // Holding registers, output stage and overflow flags.
    always_comb begin
        hold_full_d  = hold_full_q;
        hold_data_d  = hold_data_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_chan_d     = m_chan_q;
        last_grant_d = last_grant_q;
        ovf_set      = '0;
`ifdef MIC_CAPTURE_TSTAMP_EN
        hold_ts_d    = hold_ts_q;
        m_tstamp_d   = m_tstamp_q;
`endif
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (grant) begin
            m_valid_d             = 1'b1;
            m_data_d              = hold_data_q[arb_sel];
            m_chan_d              = CHAN_W'(arb_sel);
            last_grant_d          = arb_sel;
            hold_full_d[arb_sel]  = 1'b0;
`ifdef MIC_CAPTURE_TSTAMP_EN
            m_tstamp_d            = hold_ts_q[arb_sel];
`endif
        end
        // A register still full here was not granted this cycle, so the new sample is lost.
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if ((state_q == S_RUN) && cic_valid[k]) begin
                if (hold_full_d[k]) begin
                    ovf_set[k] = 1'b1;
                end else begin
                    hold_full_d[k] = 1'b1;
                    hold_data_d[k] = cic_data[k*DATA_W +: DATA_W];
`ifdef MIC_CAPTURE_TSTAMP_EN
                    hold_ts_d[k]   = ts_q;
`endif
                end
            end
        end
        if (start_take) begin
            hold_full_d = '0;
        end
        ovf_d = (ovf_clr ? '0 : ovf_q) | ovf_set;
    end

    // Sequencer next state, CIC configuration and settle counting.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        scnt_d  = scnt_q;
        comb_d  = comb_q;
        dec_d   = dec_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_wr) begin
                    comb_d = cfg_comb_num;
                    dec_d  = cfg_dec_num;
                end
                if (start) begin
                    state_d = S_CONFIG;
                    rcnt_d  = '0;
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        scnt_d[k] = '0;
                    end
                end
            end
            S_CONFIG: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (rcnt_q == RCNT_W'(RST_CYCLES - 1)) begin
                    state_d = S_SETTLE;
                end else begin
                    rcnt_d = rcnt_q + RCNT_W'(1);
                end
            end
            S_SETTLE: begin
                for (int k = 0; k < int'(NUM_CH); k++) begin
                    if (cic_valid[k] && (scnt_q[k] < CNT_W'(SETTLE_SAMPLES))) begin
                        scnt_d[k] = scnt_q[k] + CNT_W'(1);
                    end
                end
                if (stop) begin
                    state_d = S_IDLE;
                end else if (settle_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Look at next-cycle occupancy so busy drops right after the final handshake.
                if ((hold_full_d == '0) && !m_valid_d) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d    = (state_d != S_IDLE);
        cic_rst_d = (state_d == S_IDLE) || (state_d == S_CONFIG);
    end

`ifdef MIC_CAPTURE_TSTAMP_EN
    always_comb begin
        ts_d = ts_q + TS_W'(1);
        if ((state_q != S_RUN) && (state_d == S_RUN)) begin
            ts_d = '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rcnt_q       <= '0;
            comb_q       <= '0;
            dec_q        <= '0;
            busy_q       <= 1'b0;
            cic_rst_q    <= 1'b1;
            hold_full_q  <= '0;
            last_grant_q <= IDX_W'(NUM_CH - 1);
            m_data_q     <= '0;
            m_chan_q     <= '0;
            m_valid_q    <= 1'b0;
            ovf_q        <= '0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                scnt_q[k]      <= '0;
                hold_data_q[k] <= '0;
            end
`ifdef MIC_CAPTURE_TSTAMP_EN
            ts_q       <= '0;
            m_tstamp_q <= '0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                hold_ts_q[k] <= '0;
            end
`endif
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            comb_q       <= comb_d;
            dec_q        <= dec_d;
            busy_q       <= busy_d;
            cic_rst_q    <= cic_rst_d;
            hold_full_q  <= hold_full_d;
            last_grant_q <= last_grant_d;
            m_data_q     <= m_data_d;
            m_chan_q     <= m_chan_d;
            m_valid_q    <= m_valid_d;
            ovf_q        <= ovf_d;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                scnt_q[k]      <= scnt_d[k];
                hold_data_q[k] <= hold_data_d[k];
            end
`ifdef MIC_CAPTURE_TSTAMP_EN
            ts_q       <= ts_d;
            m_tstamp_q <= m_tstamp_d;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                hold_ts_q[k] <= hold_ts_d[k];
            end
`endif
        end
    end

    assign busy         = busy_q;
    assign cic_rst      = cic_rst_q;
    assign cic_comb_num = comb_q;
    assign cic_dec_num  = dec_q;
    assign m_data       = m_data_q;
    assign m_chan       = m_chan_q;
    assign m_valid      = m_valid_q;
    assign ovf          = ovf_q;
`ifdef MIC_CAPTURE_TSTAMP_EN
    assign m_tstamp     = m_tstamp_q;
`endif

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Self-checking bench for mic_capture_ctrl: directed steps plus a randomized run phase
// checked by a per-channel in-order scoreboard.
module tb_mic_capture_ctrl;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned RSTC   = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cfg_wr;
    logic [4:0]               cfg_comb_num;
    logic [7:0]               cfg_dec_num;
    logic                     start;
    logic                     stop;
    logic                     busy;
    logic                     cic_rst;
    logic [4:0]               cic_comb_num;
    logic [7:0]               cic_dec_num;
    logic [NUM_CH*DATA_W-1:0] cic_data;
    logic [NUM_CH-1:0]        cic_valid;
    logic [DATA_W-1:0]        m_data;
    logic [2:0]               m_chan;
    logic                     m_valid;
    logic                     m_ready;
    logic [NUM_CH-1:0]        ovf;
    logic                     ovf_clr;
`ifdef MIC_CAPTURE_TSTAMP_EN
    logic [31:0]              m_tstamp;
`endif

    mic_capture_ctrl #(
        .NUM_CH         (NUM_CH),
        .DATA_W         (DATA_W),
        .SETTLE_SAMPLES (SETTLE),
        .RST_CYCLES     (RSTC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_wr       (cfg_wr),
        .cfg_comb_num (cfg_comb_num),
        .cfg_dec_num  (cfg_dec_num),
        .start        (start),
        .stop         (stop),
        .busy         (busy),
        .cic_rst      (cic_rst),
        .cic_comb_num (cic_comb_num),
        .cic_dec_num  (cic_dec_num),
        .cic_data     (cic_data),
        .cic_valid    (cic_valid),
        .m_data       (m_data),
        .m_chan       (m_chan),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .ovf          (ovf),
        .ovf_clr      (ovf_clr)
`ifdef MIC_CAPTURE_TSTAMP_EN
        ,
        .m_tstamp     (m_tstamp)
`endif
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [2:0]        ch;
        logic [DATA_W-1:0] d;
    } item_t;

    item_t             sb[$];
    int                n_tests;
    int                n_fail;
    logic              run_flag;
    logic [NUM_CH-1:0] drop_mask;
    logic              last_hs;
    logic              done;
    logic [DATA_W-1:0] dv [NUM_CH];
    int                gap [NUM_CH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [DATA_W-1:0] d);
        cic_valid[k]                  = 1'b1;
        cic_data[k*DATA_W +: DATA_W]  = d;
    endtask

    // One clock: record accepted samples, advance, then check handshakes and stall stability.
    task automatic step();
        logic              hs;
        logic              stall;
        logic [DATA_W-1:0] d_pre;
        logic [2:0]        c_pre;
        item_t             it;
        int                idx;
        hs    = m_valid && m_ready && rst;
        stall = m_valid && !m_ready && rst;
        d_pre = m_data;
        c_pre = m_chan;
        if (run_flag && rst) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (cic_valid[k] && !drop_mask[k]) begin
                    it.ch = 3'(k);
                    it.d  = cic_data[k*DATA_W +: DATA_W];
                    sb.push_back(it);
                end
            end
        end
        @(posedge clk);
        #1;
        cic_valid = '0;
        drop_mask = '0;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_wr    = 1'b0;
        ovf_clr   = 1'b0;
        last_hs   = hs;
        if (hs) begin
            idx = -1;
            foreach (sb[i]) begin
                if (idx < 0 && sb[i].ch == c_pre) idx = i;
            end
            chk("hs_expected", 64'(idx >= 0), 64'd1);
            if (idx >= 0) begin
                chk("hs_data", 64'(d_pre), 64'(sb[idx].d));
                sb.delete(idx);
            end
        end
        if (stall) begin
            chk("stall_valid", 64'(m_valid), 64'd1);
            chk("stall_data", 64'(m_data), 64'(d_pre));
            chk("stall_chan", 64'(m_chan), 64'(c_pre));
        end
    endtask

    task automatic drain(input string tag);
        m_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        step();
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    // Called one clock after start: cic_rst must stay high for RSTC clocks in total.
    task automatic check_rst_window();
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_cic_rst", 64'(cic_rst), 64'd1);
        for (int i = 1; i < int'(RSTC); i++) begin
            step();
            chk("cfg_cic_rst_hi", 64'(cic_rst), 64'd1);
        end
        step();
        chk("cfg_cic_rst_lo", 64'(cic_rst), 64'd0);
        chk("cfg_busy", 64'(busy), 64'd1);
    endtask

    task automatic do_settle();
        for (int r = 0; r < int'(SETTLE); r++) begin
            for (int k = 0; k < int'(NUM_CH); k++) set_ch(k, $urandom);
            step();
            chk("settle_no_valid", 64'(m_valid), 64'd0);
            step();
            chk("settle_no_valid", 64'(m_valid), 64'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk("settle_no_valid", 64'(m_valid), 64'd0);
        end
        run_flag = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0; n_fail = 0; run_flag = 1'b0; drop_mask = '0; last_hs = 1'b0; done = 1'b0;
        rst = 1'b0; cfg_wr = 1'b0; cfg_comb_num = '0; cfg_dec_num = '0; start = 1'b0;
        stop = 1'b0; cic_data = '0; cic_valid = '0; m_ready = 1'b1; ovf_clr = 1'b0;
        #1;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cic_rst", 64'(cic_rst), 64'd1);
        chk("rst_comb", 64'(cic_comb_num), 64'd0);
        chk("rst_dec", 64'(cic_dec_num), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_chan", 64'(m_chan), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b1;

        // Configuration, start and settle discard
        cfg_wr = 1'b1; cfg_comb_num = 5'd8; cfg_dec_num = 8'd63;
        step();
        chk("cfg_comb", 64'(cic_comb_num), 64'd8);
        chk("cfg_dec", 64'(cic_dec_num), 64'd63);
        chk("cfg_busy_idle", 64'(busy), 64'd0);
        start = 1'b1;
        step();
        cfg_wr = 1'b1; cfg_comb_num = 5'd3; cfg_dec_num = 8'd9;
        check_rst_window();
        chk("cfg_locked_comb", 64'(cic_comb_num), 64'd8);
        chk("cfg_locked_dec", 64'(cic_dec_num), 64'd63);
        do_settle();

        // All four channels at once: round-robin from channel 0
        m_ready = 1'b1;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            dv[k] = $urandom;
            set_ch(k, dv[k]);
        end
        step();
        chk("rr_latency", 64'(m_valid), 64'd0);
        for (int k = 0; k < int'(NUM_CH); k++) begin
            step();
            chk("rr_valid", 64'(m_valid), 64'd1);
            chk("rr_chan", 64'(m_chan), 64'(k));
            chk("rr_data", 64'(m_data), 64'(dv[k]));
        end
        drain("rr_drain");

        // Overflow on channel 2 while output stalled
        m_ready = 1'b0;
        dv[0] = $urandom; set_ch(0, dv[0]);
        step();
        step();
        chk("stall_first_valid", 64'(m_valid), 64'd1);
        chk("stall_first_data", 64'(m_data), 64'(dv[0]));
        step();
        set_ch(2, $urandom);
        step();
        chk("ovf_none_yet", 64'(ovf), 64'd0);
        set_ch(2, $urandom); drop_mask = 4'b0100;
        step();
        chk("ovf_ch2", 64'(ovf), 64'b0100);
        set_ch(2, $urandom); drop_mask = 4'b0100; ovf_clr = 1'b1;
        step();
        chk("ovf_set_wins", 64'(ovf), 64'b0100);
        ovf_clr = 1'b1;
        step();
        chk("ovf_clr", 64'(ovf), 64'd0);
        drain("ovf_drain");

        // Store into channel 1 in the same cycle it is granted
        m_ready = 1'b1;
        set_ch(1, $urandom);
        step();
        set_ch(1, $urandom);
        step();
        chk("grant_store_ovf", 64'(ovf), 64'd0);
        drain("grant_store_drain");
        chk("grant_store_ovf_end", 64'(ovf), 64'd0);

        // Stop with three full registers and a toggling ready
        m_ready = 1'b0;
        set_ch(0, $urandom);
        step();
        step();
        for (int k = 1; k < int'(NUM_CH); k++) set_ch(k, $urandom);
        step();
        stop = 1'b1;
        step();
        run_flag = 1'b0;
        chk("drain_busy", 64'(busy), 64'd1);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            m_ready = ~m_ready;
            step();
            if (last_hs && sb.size() == 0) begin
                done = 1'b1;
                chk("drain_busy_fall", 64'(busy), 64'd0);
                chk("drain_cic_rst", 64'(cic_rst), 64'd1);
            end
        end
        chk("drain_done", 64'(done), 64'd1);
        m_ready = 1'b1;
        for (int k = 0; k < int'(NUM_CH); k++) set_ch(k, $urandom);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_ignore_valid", 64'(m_valid), 64'd0);
        end

        // Stop during CONFIG returns to IDLE
        start = 1'b1;
        step();
        chk("cfgstop_busy", 64'(busy), 64'd1);
        stop = 1'b1;
        step();
        chk("cfgstop_idle", 64'(busy), 64'd0);
        chk("cfgstop_cic_rst", 64'(cic_rst), 64'd1);

        // cfg_wr together with start
        cfg_wr = 1'b1; cfg_comb_num = 5'd17; cfg_dec_num = 8'd200; start = 1'b1;
        step();
        chk("cfgstart_comb", 64'(cic_comb_num), 64'd17);
        chk("cfgstart_dec", 64'(cic_dec_num), 64'd200);
        check_rst_window();
        do_settle();

        // Randomized traffic, spaced so no channel can overflow
        m_ready = 1'b1;
        for (int k = 0; k < int'(NUM_CH); k++) gap[k] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (gap[k] > 0) gap[k]--;
                else if ($urandom_range(2) == 0) begin
                    set_ch(k, $urandom);
                    gap[k] = 5 + int'($urandom_range(3));
                end
            end
            step();
        end
        drain("rand_drain");
        chk("rand_ovf", 64'(ovf), 64'd0);

        // Reset while a sample is held at the output
        m_ready = 1'b0;
        set_ch(0, $urandom);
        step();
        step();
        chk("prerst_valid", 64'(m_valid), 64'd1);
        set_ch(1, $urandom);
        step();
        set_ch(1, $urandom); drop_mask = 4'b0010;
        step();
        chk("prerst_ovf", 64'(ovf), 64'b0010);
        rst = 1'b0;
        step();
        chk("midrst_valid", 64'(m_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cic_rst", 64'(cic_rst), 64'd1);
        chk("midrst_ovf", 64'(ovf), 64'd0);
        chk("midrst_data", 64'(m_data), 64'd0);
        rst = 1'b1;
        sb.delete();
        run_flag = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst_empty", 64'(m_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mic_capture_ctrl.md
# mic_capture_ctrl

Sequencing and arbitration controller for a bank of `NUM_CH` CIC decimators, one per microphone. It owns the CIC reset and rate configuration, and holds the filters in reset while rates change. After start-up it discards the settling samples, then merges the per-channel CIC outputs into one valid/ready stream tagged with the channel number. It sits between the CIC instances and the downstream sample FIFO / packetizer.

## Interface
- `NUM_CH`, 4, number of CIC channels (2..8)
- `DATA_W`, 32, CIC sample width
- `SETTLE_SAMPLES`, 2, valid samples discarded per channel after each start (0..15)
- `RST_CYCLES`, 4, clocks `cic_rst` stays high in CONFIG (1..255)
- `clk`  in  1  system clock, 50 MHz
- `rst`  in  1  synchronous reset, active-low: `rst`=0 at a `clk` rising edge resets the block
- `cfg_wr`  in  1  latch `cfg_comb_num`/`cfg_dec_num`; honoured only in IDLE
- `cfg_comb_num`  in  5  requested comb delay
- `cfg_dec_num`  in  8  requested decimation count
- `start`  in  1  single-cycle pulse; honoured only in IDLE
- `stop`  in  1  single-cycle pulse; honoured in CONFIG, SETTLE, RUN
- `busy`  out  1  high in every state except IDLE
- `cic_rst`  out  1  active-high reset to all CICs
- `cic_comb_num`  out  5  registered comb delay to all CICs
- `cic_dec_num`  out  8  registered decimation count to all CICs
- `cic_data`  in  NUM_CH*DATA_W  channel k in bits [k*DATA_W +: DATA_W]
- `cic_valid`  in  NUM_CH  one-cycle valid per channel
- `m_data`  out  DATA_W  merged sample
- `m_chan`  out  3  source channel of `m_data`
- `m_valid`  out  1  output valid
- `m_ready`  in  1  downstream ready
- `ovf`  out  NUM_CH  sticky per-channel overflow flags
- `ovf_clr`  in  1  clear all `ovf` bits

## Operation
- States and transitions:
  - IDLE: after `start`, go to CONFIG.
  - CONFIG: hold for `RST_CYCLES` clocks, then go to SETTLE.
  - SETTLE: once every channel has discarded `SETTLE_SAMPLES` valids, go to RUN. With `SETTLE_SAMPLES`=0, SETTLE lasts one clock.
  - RUN: after `stop`, go to DRAIN.
  - DRAIN: once all holding registers are empty and `m_valid`=0, go to IDLE.
  - `stop` in CONFIG or SETTLE goes straight to IDLE.
- `cic_rst` is 1 in IDLE and CONFIG and 0 otherwise.
- `cic_comb_num` and `cic_dec_num` change only on `cfg_wr` in IDLE.
- `cfg_wr` and `start` in the same cycle: the configuration is latched and the start is taken, so the CICs come up with the new rates.
- Holding registers: each channel has one data register plus a full flag.
  - In RUN, a `cic_valid[k]` pulse stores the sample into channel k's register.
  - If the register is full and is not being granted this cycle, the new sample is dropped and `ovf[k]` is set.
  - If the register is being granted in the same cycle, the new sample is stored and no overflow is flagged.
- In SETTLE, `cic_valid` is counted per channel and the data is discarded. In IDLE, CONFIG and DRAIN, `cic_valid` is ignored.
- Arbiter: round-robin over full registers, starting at the channel after the last grant. After reset the last grant is `NUM_CH`-1, so channel 0 has first priority.
  - A grant occurs when `m_valid`=0, or `m_valid`=1 and `m_ready`=1.
  - On a grant, the selected sample loads into `m_data`/`m_chan` and the register empties.
- Output stream: `m_data` and `m_chan` stay stable while `m_valid`=1 and `m_ready`=0.
- `ovf_clr` clears all `ovf` bits. If `ovf_clr` and an overflow occur in the same cycle, the set wins.
- `start` resets the settle counters and empties all holding registers. `ovf` is not affected.

## Timing
- Reset values:
  - Outputs: `busy`=0, `cic_rst`=1, `cic_comb_num`=0, `cic_dec_num`=0, `m_data`=0, `m_chan`=0, `m_valid`=0, `ovf`=0.
  - Internal: state IDLE, all holding registers empty.
- Reset mid-operation discards all held data immediately.
- `start` at cycle t:
  - `busy`=1 and `cic_rst`=1 at t+1.
  - `cic_rst`=0 at t+1+`RST_CYCLES`.
- Latency: a `cic_valid[k]` pulse at cycle n makes the register full at n+1 and gives `m_valid`=1 at n+2 if the output is free and channel k wins arbitration.
- Sustained throughput is one sample per clock.
- `stop` at cycle t puts the block in DRAIN at t+1. `busy` falls on the cycle after the last `m_valid`&`m_ready` handshake.

## Configuration
- `MIC_CAPTURE_TSTAMP_EN` defined:
  - Adds output `m_tstamp` (32 bits), plus a 32-bit free-running counter that clears on entry to RUN and increments every clock.
  - Each holding register captures the counter value on its `cic_valid`. `m_tstamp` travels with `m_data` and resets to 0.
- Not defined: no `m_tstamp` port and no counter. All other behaviour is identical.

## Test plan
- Reset, then `cfg_wr` with comb=8, dec=63, then `start`: `cic_comb_num`=8 and `cic_dec_num`=63; `cic_rst` is high for exactly 4 clocks; the first 2 valids per channel produce no `m_valid`.
- RUN with `m_ready`=1 and `cic_valid`=4'b1111 in one cycle: channels 0, 1, 2, 3 appear on four consecutive cycles with their matching data.
- `m_ready`=0 while channel 2 receives 2 valids: `ovf[2]`=1 and the first sample is preserved. `ovf_clr` then returns `ovf` to 0.
- Valid on channel 1 in the same cycle as its grant: both samples are delivered in order and `ovf[1]` stays 0.
- `stop` with 3 full registers and `m_ready` toggling: all 3 samples are delivered, then `busy`=0, `cic_rst`=1, and later `cic_valid` pulses are ignored.
- `rst`=0 asserted in RUN with `m_valid`=1: the next cycle shows `m_valid`=0, `busy`=0, `cic_rst`=1, and `ovf` cleared.
